// File: rtl/cla_pipe_adder_pkg.sv
// Shared defaults for the pipelined carry look-ahead adder.
// NGROUP is derived from WIDTH/BLOCK and is also the pipeline depth.
package cla_pipe_adder_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int BLOCK_DEF = 4;

    function automatic int ngroup(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand-in / result-out stream bundle for cla_pipe_adder.
// master is the side that issues operands and consumes results.
interface cla_pipe_adder_if
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

endinterface

// File: rtl/cla_group.sv
// One BLOCK-bit carry look-ahead group, purely combinational.
// Every internal carry is a flat sum-of-products of g/p/ci; nothing ripples.
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        logic acc;
        logic prod;
        acc    = 1'b0;
        prod   = 1'b0;
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            acc = w_g[i];
            // generate at bit j propagated through bits j+1..i
            for (int j = 0; j < i; j++) begin
                prod = w_g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & w_p[m];
                end
                acc = acc | prod;
            end
            prod = ci;
            for (int m = 0; m <= i; m++) begin
                prod = prod & w_p[m];
            end
            w_c[i+1] = acc | prod;
        end
    end

    assign s     = w_p ^ w_c[BLOCK-1:0];
    assign co    = w_c[BLOCK];
    assign c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one look-ahead group resolved per stage,
// carry registered between stages, whole pipe stalls when the output is blocked.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave io
);

    localparam int NGROUP = ngroup(WIDTH, BLOCK);

    if ((BLOCK < 1) || (WIDTH % BLOCK != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [NGROUP-1:0] r_v;
    logic [NGROUP-1:0] r_c;
    logic              r_cmsb;
    logic [WIDTH-1:0]  r_a   [NGROUP];
    logic [WIDTH-1:0]  r_b   [NGROUP];
    logic [WIDTH-1:0]  r_sum [NGROUP];

    logic              w_adv;
    logic [NGROUP-1:0] w_v_nx;
    logic [NGROUP-1:0] w_c_st;
    logic [NGROUP-1:0] w_gco;
    logic              w_gcmsb  [NGROUP];
    logic [BLOCK-1:0]  w_gs     [NGROUP];
    logic [WIDTH-1:0]  w_a_st   [NGROUP];
    logic [WIDTH-1:0]  w_b_st   [NGROUP];
    logic [WIDTH-1:0]  w_sum_st [NGROUP];
    logic [WIDTH-1:0]  w_sum_nx [NGROUP];

    assign w_adv = !r_v[NGROUP-1] || io.out_ready;

    // Stage 0 takes the live operands; later stages take the previous stage's registers.
    always_comb begin
        w_v_nx      = '0;
        w_c_st      = '0;
        w_a_st      = '{default: '0};
        w_b_st      = '{default: '0};
        w_sum_st    = '{default: '0};
        w_sum_nx    = '{default: '0};
        w_v_nx[0]   = io.in_valid;
        w_a_st[0]   = io.a;
        w_b_st[0]   = io.sub ? ~io.b : io.b;
        w_c_st[0]   = io.sub | io.cin;
        for (int k = 1; k < NGROUP; k++) begin
            w_v_nx[k]   = r_v[k-1];
            w_a_st[k]   = r_a[k-1];
            w_b_st[k]   = r_b[k-1];
            w_c_st[k]   = r_c[k-1];
            w_sum_st[k] = r_sum[k-1];
        end
        for (int k = 0; k < NGROUP; k++) begin
            w_sum_nx[k]                  = w_sum_st[k];
            w_sum_nx[k][k*BLOCK +: BLOCK] = w_gs[k];
        end
    end

    for (genvar k = 0; k < NGROUP; k++) begin : g_grp
        cla_group #(
            .BLOCK (BLOCK)
        ) u_grp (
            .a     (w_a_st[k][k*BLOCK +: BLOCK]),
            .b     (w_b_st[k][k*BLOCK +: BLOCK]),
            .ci    (w_c_st[k]),
            .s     (w_gs[k]),
            .co    (w_gco[k]),
            .c_msb (w_gcmsb[k])
        );
    end

    // Data registers are reset too so outputs never expose X, even on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_c    <= '0;
            r_cmsb <= 1'b0;
            r_a    <= '{default: '0};
            r_b    <= '{default: '0};
            r_sum  <= '{default: '0};
        end else if (w_adv) begin
            r_v    <= w_v_nx;
            r_c    <= w_gco;
            r_cmsb <= w_gcmsb[NGROUP-1];
            r_a    <= w_a_st;
            r_b    <= w_b_st;
            r_sum  <= w_sum_nx;
        end
    end

    assign io.in_ready  = w_adv;
    assign io.out_valid = r_v[NGROUP-1];
    assign io.s         = r_sum[NGROUP-1];
    assign io.cout      = r_c[NGROUP-1];
    assign io.ovf       = r_cmsb ^ r_c[NGROUP-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4).
module tb_cla_pipe_adder;
    import cla_pipe_adder_pkg::*;

    localparam int W  = 16;
    localparam int BL = 4;
    localparam int NG = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) io ();

    cla_pipe_adder #(
        .WIDTH (W),
        .BLOCK (BL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    vec_t         vecs [10];
    logic [17:0]  exp_q [$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           n_pop    = 0;
    int           acc_cyc  = 0;
    int           last_pop_cyc = 0;

    function automatic logic [17:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         ov;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov   = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], ov};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        io.in_valid = v;
        io.a        = a;
        io.b        = b;
        io.cin      = cin;
        io.sub      = sub;
    endtask

    // One clock: settle, log the handshakes the coming edge will perform, cross the edge.
    task automatic step(input logic [17:0] e);
        logic [17:0] got;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(e);
                acc_cyc = cyc;
            end
            if (io.out_valid && io.out_ready) begin
                n_pop++;
                last_pop_cyc = cyc;
                got = {io.s, io.cout, io.ovf};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%0h required=none", got);
                end else begin
                    chk("result", {14'b0, got}, {14'b0, exp_q.pop_front()});
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step('0);
    endtask

    initial begin
        int p0;
        int c0;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        io.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, io.out_valid}, 0);
        chk("rst_s", {16'b0, io.s}, 0);
        chk("rst_cout_ovf", {30'b0, io.cout, io.ovf}, 0);
        chk("rst_in_ready", {31'b0, io.in_ready}, 1);

        // Latency of a lone beat carrying across every group.
        io.out_ready = 1'b1;
        drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub);
        step({vecs[0].s, vecs[0].cout, vecs[0].ovf});
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        p0 = n_pop;
        for (int i = 0; i < 12 && n_pop == p0; i++) step('0);
        chk("latency_pops", n_pop - p0, 1);
        chk("latency", last_pop_cyc - acc_cyc, NG);

        // Directed table, back to back.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            step({vecs[i].s, vecs[i].cout, vecs[i].ovf});
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain(20);
        chk("table_drain", exp_q.size(), 0);

        // Eight random beats streamed; results must come out on consecutive cycles.
        p0 = n_pop;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            drive(1'b1, ra, rb, rc, rs);
            step(ref_add(ra, rb, rc, rs));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain(20);
        chk("stream_pops", n_pop - p0, 8);
        chk("stream_last_cycle", last_pop_cyc - c0, 7 + NG);

        // Backpressure: fill the pipe with out_ready low, then stall three cycles.
        io.out_ready = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            drive(1'b1, ra, rb, rc, rs);
            step(ref_add(ra, rb, rc, rs));
        end
        chk("bp_accepted", exp_q.size(), 4);
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            drive(1'b1, ra, rb, 1'b0, 1'b0);
            #1;
            chk("bp_in_ready", {31'b0, io.in_ready}, 0);
            chk("bp_out_valid", {31'b0, io.out_valid}, 1);
            if (exp_q.size() != 0)
                chk("bp_hold", {14'b0, io.s, io.cout, io.ovf}, {14'b0, exp_q[0]});
            step(ref_add(ra, rb, 1'b0, 1'b0));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        io.out_ready = 1'b1;
        drain(20);
        chk("bp_pops", n_pop - p0, 4);
        chk("bp_drain", exp_q.size(), 0);

        // Reset with three beats in flight: nothing from them may appear.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vecs[i+4].a, vecs[i+4].b, vecs[i+4].cin, vecs[i+4].sub);
            step({vecs[i+4].s, vecs[i+4].cout, vecs[i+4].ovf});
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step('0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, io.out_valid}, 0);
        p0 = n_pop;
        repeat (6) step('0);
        chk("midrst_no_leak", n_pop - p0, 0);
        drive(1'b1, vecs[3].a, vecs[3].b, vecs[3].cin, vecs[3].sub);
        step({vecs[3].s, vecs[3].cout, vecs[3].ovf});
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        p0 = n_pop;
        for (int i = 0; i < 12 && n_pop == p0; i++) step('0);
        chk("post_rst_pops", n_pop - p0, 1);
        chk("post_rst_latency", last_pop_cyc - acc_cyc, NG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
